// File: rtl/rr_reg_bank_arbiter_pkg.sv
// Shared defaults and index-width helper for the round-robin register bank arbiter.
package rr_reg_bank_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_WIDTH    = 16;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_reg_bank_arbiter_reg.sv
// Single bank entry: enabled register with asynchronous active-high reset to RESET_VALUE.
module rr_reg_bank_arbiter_reg
    import rr_reg_bank_arbiter_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] value_q;

    always_comb begin
        value_d = en ? d : value_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/rr_reg_bank_arbiter.sv
// Register bank written by NUM_REQ requesters through a round-robin arbiter;
// one write per cycle, combinational read port, registered grant report.
module rr_reg_bank_arbiter
    import rr_reg_bank_arbiter_pkg::*;
#(
    parameter int               NUM_REQ     = DEF_NUM_REQ,
    parameter int               NUM_REGS    = DEF_NUM_REGS,
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*idx_w(NUM_REGS)-1:0]   req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]             req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [idx_w(NUM_REGS)-1:0]           rd_addr,
    output logic [WIDTH-1:0]                     rd_data,
    output logic                                 grant_valid,
    output logic [idx_w(NUM_REQ)-1:0]            grant_id
);

    localparam int AW = idx_w(NUM_REGS);
    localparam int IW = idx_w(NUM_REQ);

    logic [IW-1:0]    ptr_q, ptr_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             accept;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] bank_q [NUM_REGS];

    // Round-robin search starting at ptr_q; clear and reset veto the grant.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
        req_ready = '0;
        if (win_found && !clear && !rst) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign accept   = win_found & ~clear & ~rst;
    assign win_addr = req_addr[win_idx*AW +: AW];
    assign win_data = req_data[win_idx*WIDTH +: WIDTH];

    always_comb begin
        ptr_d         = ptr_q;
        grant_valid_d = 1'b0;
        grant_id_d    = grant_id_q;
        if (accept) begin
            ptr_d         = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            grant_valid_d = 1'b1;
            grant_id_d    = win_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    // Out-of-range addresses match no entry, so such writes are dropped silently.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_bank
        logic             we;
        logic [WIDTH-1:0] wd;
        assign we = clear | (accept && (win_addr == AW'(k)));
        assign wd = clear ? RESET_VALUE : win_data;
        rr_reg_bank_arbiter_reg #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (we),
            .d   (wd),
            .q   (bank_q[k])
        );
    end

    always_comb begin
        rd_data = RESET_VALUE;
        if (int'(rd_addr) < NUM_REGS) begin
            rd_data = bank_q[rd_addr];
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule
